// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// FSM encodings plus default data/address widths.
package reg_file_pkg;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy vector for in-flight destinations.
// Set by reserve, cleared by write or by the sweep index.
module rf_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic              swp_en,
   input  logic [ADDR_W-1:0] swp_addr,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              a_busy,
   output logic              b_busy
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nx;

   // Reserve is applied after the write clear so it wins on a collision.
   always_comb begin
      busy_nx = busy;
      if (swp_en) begin
         busy_nx[swp_addr] = 1'b0;
      end else begin
         if (clr_en) busy_nx[clr_addr] = 1'b0;
         if (set_en) busy_nx[set_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nx;
   end

   assign a_busy = busy[a_addr];
   assign b_busy = busy[b_addr];

endmodule

// File: rtl/reg_file_sb.sv
// Two-read one-write register file with busy scoreboard,
// optional zero register, write bypass and a clear sweep.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic              rs_ready,
   output logic              rt_ready,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              clr_req,
   output logic              clr_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return !(ZERO_REG && (a == '0));
   endfunction

   rf_state_e         state;
   rf_state_e         state_nx;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_nx;
   logic [DATA_W-1:0] regs [DEPTH];

   logic              idle;
   logic              wr_ok;
   logic              rsv_ok;
   logic [ADDR_W-1:0] swp_idx;
   logic              rs_busy;
   logic              rt_busy;
   logic              rs_hit;
   logic              rt_hit;
   logic              rs_zero;
   logic              rt_zero;

   assign idle    = (state == RF_IDLE);
   assign wr_ok   = idle && we && writable(wr_addr);
   assign rsv_ok  = idle && rsv_en && writable(rsv_addr);
   assign swp_idx = cnt[ADDR_W-1:0];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         RF_IDLE: begin
            if (clr_req) begin
               state_nx = RF_CLEAR;
               cnt_nx   = '0;
            end
         end
         RF_CLEAR: begin
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) state_nx = RF_IDLE;
         end
         default: state_nx = RF_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RF_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (!idle) begin
         regs[swp_idx] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (rsv_ok),
      .set_addr (rsv_addr),
      .clr_en   (wr_ok),
      .clr_addr (wr_addr),
      .swp_en   (!idle),
      .swp_addr (swp_idx),
      .a_addr   (rs_addr),
      .b_addr   (rt_addr),
      .a_busy   (rs_busy),
      .b_busy   (rt_busy)
   );

   // wr_ok already excludes the sweep and the zero register.
   assign rs_hit  = BYPASS && wr_ok && (wr_addr == rs_addr);
   assign rt_hit  = BYPASS && wr_ok && (wr_addr == rt_addr);
   assign rs_zero = ZERO_REG && (rs_addr == '0);
   assign rt_zero = ZERO_REG && (rt_addr == '0);

   always_comb begin
      rs_data = regs[rs_addr];
      if (rs_zero) rs_data = '0;
      if (rs_hit)  rs_data = wr_data;
      rt_data = regs[rt_addr];
      if (rt_zero) rt_data = '0;
      if (rt_hit)  rt_data = wr_data;
   end

   assign rs_ready = rs_hit || rs_zero || !rs_busy;
   assign rt_ready = rt_hit || rt_zero || !rt_busy;
   assign clr_busy = !idle;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: expectations are queued
// when stimulus is driven and popped when outputs are sampled.
module tb_reg_file_sb;

   typedef struct {
      logic [31:0] data;
      logic        ready;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rs_ready;
   logic        rt_ready;
   logic        we;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        clr_req;
   logic        clr_busy;

   exp_t exp_q[$];
   exp_t e;
   int   checks;
   int   failures;

   reg_file_sb dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs_addr  (rs_addr),
      .rt_addr  (rt_addr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .rs_ready (rs_ready),
      .rt_ready (rt_ready),
      .we       (we),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .clr_req  (clr_req),
      .clr_busy (clr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      we       = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      clr_req  = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rs_addr = '0;
      rt_addr = '0;
      rst_n   = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(31 - i);
         exp_q.push_back('{32'h0, 1'b1});
         exp_q.push_back('{32'h0, 1'b1});
         #1;
         e = exp_q.pop_front();
         checks++;
         if (rs_data !== e.data || rs_ready !== e.ready) begin
            failures++;
            $display("FAIL reset_rs a=%0d got %h/%b want %h/%b",
                     i, rs_data, rs_ready, e.data, e.ready);
         end
         e = exp_q.pop_front();
         checks++;
         if (rt_data !== e.data || rt_ready !== e.ready) begin
            failures++;
            $display("FAIL reset_rt a=%0d got %h/%b want %h/%b",
                     31 - i, rt_data, rt_ready, e.data, e.ready);
         end
      end
      checks++;
      if (clr_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_clr_busy got %b want 0", clr_busy);
      end
      @(negedge clk);
   endtask

   task automatic test_bypass();
      we      = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'hDEAD_BEEF;
      rs_addr = 5'd5;
      exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rs_data !== e.data || rs_ready !== e.ready) begin
         failures++;
         $display("FAIL bypass_same got %h/%b want %h/%b",
                  rs_data, rs_ready, e.data, e.ready);
      end
      step();
      we = 1'b0;
      exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rs_data !== e.data || rs_ready !== e.ready) begin
         failures++;
         $display("FAIL bypass_after got %h/%b want %h/%b",
                  rs_data, rs_ready, e.data, e.ready);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_reg();
      we       = 1'b1;
      wr_addr  = 5'd0;
      wr_data  = 32'h1234;
      rsv_en   = 1'b1;
      rsv_addr = 5'd0;
      rs_addr  = 5'd0;
      exp_q.push_back('{32'h0, 1'b1});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rs_data !== e.data || rs_ready !== e.ready) begin
         failures++;
         $display("FAIL zero_same got %h/%b want %h/%b",
                  rs_data, rs_ready, e.data, e.ready);
      end
      step();
      idle_inputs();
      exp_q.push_back('{32'h0, 1'b1});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rs_data !== e.data || rs_ready !== e.ready) begin
         failures++;
         $display("FAIL zero_after got %h/%b want %h/%b",
                  rs_data, rs_ready, e.data, e.ready);
      end
      @(negedge clk);
   endtask

   task automatic test_reserve();
      rsv_en   = 1'b1;
      rsv_addr = 5'd7;
      rt_addr  = 5'd7;
      rs_addr  = 5'd5;
      step();
      rsv_en = 1'b0;
      exp_q.push_back('{32'h0, 1'b0});
      exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rt_data !== e.data || rt_ready !== e.ready) begin
         failures++;
         $display("FAIL rsv_busy got %h/%b want %h/%b",
                  rt_data, rt_ready, e.data, e.ready);
      end
      e = exp_q.pop_front();
      checks++;
      if (rs_data !== e.data || rs_ready !== e.ready) begin
         failures++;
         $display("FAIL rsv_other got %h/%b want %h/%b",
                  rs_data, rs_ready, e.data, e.ready);
      end
      @(negedge clk);
      rsv_en = 1'b1;
      step();
      rsv_en = 1'b0;
      exp_q.push_back('{32'h0, 1'b0});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rt_data !== e.data || rt_ready !== e.ready) begin
         failures++;
         $display("FAIL rsv_twice got %h/%b want %h/%b",
                  rt_data, rt_ready, e.data, e.ready);
      end
      @(negedge clk);
      we      = 1'b1;
      wr_addr = 5'd7;
      wr_data = 32'h55;
      exp_q.push_back('{32'h55, 1'b1});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rt_data !== e.data || rt_ready !== e.ready) begin
         failures++;
         $display("FAIL rsv_wr_bypass got %h/%b want %h/%b",
                  rt_data, rt_ready, e.data, e.ready);
      end
      step();
      we = 1'b0;
      exp_q.push_back('{32'h55, 1'b1});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rt_data !== e.data || rt_ready !== e.ready) begin
         failures++;
         $display("FAIL rsv_wr_after got %h/%b want %h/%b",
                  rt_data, rt_ready, e.data, e.ready);
      end
      @(negedge clk);
      we       = 1'b1;
      wr_data  = 32'h77;
      rsv_en   = 1'b1;
      rsv_addr = 5'd7;
      step();
      idle_inputs();
      exp_q.push_back('{32'h77, 1'b0});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rt_data !== e.data || rt_ready !== e.ready) begin
         failures++;
         $display("FAIL rsv_wins got %h/%b want %h/%b",
                  rt_data, rt_ready, e.data, e.ready);
      end
      @(negedge clk);
   endtask

   task automatic test_clear_sweep();
      int n;
      for (int i = 1; i < 32; i++) begin
         we      = 1'b1;
         wr_addr = 5'(i);
         wr_data = 32'(i);
         step();
      end
      we       = 1'b0;
      rsv_en   = 1'b1;
      rsv_addr = 5'd9;
      step();
      rsv_en  = 1'b0;
      rs_addr = 5'd17;
      rt_addr = 5'd9;
      exp_q.push_back('{32'd17, 1'b1});
      exp_q.push_back('{32'd9, 1'b0});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (rs_data !== e.data || rs_ready !== e.ready) begin
         failures++;
         $display("FAIL fill_rs got %h/%b want %h/%b",
                  rs_data, rs_ready, e.data, e.ready);
      end
      e = exp_q.pop_front();
      checks++;
      if (rt_data !== e.data || rt_ready !== e.ready) begin
         failures++;
         $display("FAIL fill_rt got %h/%b want %h/%b",
                  rt_data, rt_ready, e.data, e.ready);
      end
      @(negedge clk);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         we      = 1'b0;
         clr_req = 1'b0;
         if (k == 9) begin
            we      = 1'b1;
            wr_addr = 5'd2;
            wr_data = 32'hFFFF_0000;
            rs_addr = 5'd2;
            rt_addr = 5'd20;
            exp_q.push_back('{32'h0, 1'b1});
            exp_q.push_back('{32'd20, 1'b1});
         end
         if (k == 20) clr_req = 1'b1;
         #2;
         if (!clr_busy) break;
         n++;
         if (k == 9) begin
            e = exp_q.pop_front();
            checks++;
            if (rs_data !== e.data || rs_ready !== e.ready) begin
               failures++;
               $display("FAIL sweep_nobypass got %h/%b want %h/%b",
                        rs_data, rs_ready, e.data, e.ready);
            end
            e = exp_q.pop_front();
            checks++;
            if (rt_data !== e.data || rt_ready !== e.ready) begin
               failures++;
               $display("FAIL sweep_partial got %h/%b want %h/%b",
                        rt_data, rt_ready, e.data, e.ready);
            end
         end
         @(negedge clk);
      end
      idle_inputs();
      checks++;
      if (n !== 32) begin
         failures++;
         $display("FAIL sweep_len got %0d want 32", n);
      end
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         exp_q.push_back('{32'h0, 1'b1});
         #1;
         e = exp_q.pop_front();
         checks++;
         if (rs_data !== e.data || rs_ready !== e.ready) begin
            failures++;
            $display("FAIL swept a=%0d got %h/%b want %h/%b",
                     i, rs_data, rs_ready, e.data, e.ready);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_sweep();
      we      = 1'b1;
      wr_addr = 5'd30;
      wr_data = 32'hABCD;
      step();
      we       = 1'b0;
      rsv_en   = 1'b1;
      rsv_addr = 5'd25;
      step();
      rsv_en  = 1'b0;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (10) step();
      rs_addr = 5'd25;
      rt_addr = 5'd30;
      #1;
      rst_n = 1'b0;
      exp_q.push_back('{32'h0, 1'b1});
      exp_q.push_back('{32'h0, 1'b1});
      #1;
      checks++;
      if (clr_busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_busy got %b want 0", clr_busy);
      end
      e = exp_q.pop_front();
      checks++;
      if (rs_data !== e.data || rs_ready !== e.ready) begin
         failures++;
         $display("FAIL rst_mid_rs got %h/%b want %h/%b",
                  rs_data, rs_ready, e.data, e.ready);
      end
      e = exp_q.pop_front();
      checks++;
      if (rt_data !== e.data || rt_ready !== e.ready) begin
         failures++;
         $display("FAIL rst_mid_rt got %h/%b want %h/%b",
                  rt_data, rt_ready, e.data, e.ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      rs_addr  = '0;
      rt_addr  = '0;
      idle_inputs();
      test_reset();
      test_bypass();
      test_zero_reg();
      test_reserve();
      test_clear_sweep();
      test_reset_mid_sweep();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_left got %0d want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
